// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl: GPIO pad synchronizer plus per-pin edge interrupt controller.
// Register map: 0x00 IRQ_EN, 0x04 IRQ_RISE, 0x08 IRQ_FALL, 0x0C IRQ_STATUS (W1C),
// 0x10 PIN_STATE (RO). Define GPIO_IRQ_DEBOUNCE_EN to add a per-bit debounce
// filter of DEBOUNCE_CNT stable cycles between the synchronizer and gpio_sync.
module gpio_irq_ctrl #(
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_valid,
    input  logic        bus_we,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    input  logic [31:0] gpio_pin,
    output logic [31:0] gpio_sync,
    output logic        irq
);
    localparam logic [7:0] ADDR_EN     = 8'h00;
    localparam logic [7:0] ADDR_RISE   = 8'h04;
    localparam logic [7:0] ADDR_FALL   = 8'h08;
    localparam logic [7:0] ADDR_STATUS = 8'h0C;
    localparam logic [7:0] ADDR_PIN    = 8'h10;

    logic [31:0] sync1_r;
    logic [31:0] sync2_r;
    logic [31:0] prev_r;
    logic [31:0] irq_en_r;
    logic [31:0] irq_rise_r;
    logic [31:0] irq_fall_r;
    logic [31:0] irq_status_r;
    logic [31:0] gpio_sync_s;
    logic [31:0] edge_set_s;
    logic [31:0] w1c_s;
    logic [7:0]  addr_s;
    logic        wr_en_s;
    logic        unused_addr_s;

    // Only the low address byte is decoded; the upper bits are intentionally ignored.
    assign unused_addr_s = ^bus_addr[31:8];

    // Two-flop synchronizer on the raw, asynchronous pad inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 32'h0;
            sync2_r <= 32'h0;
        end else begin
            sync1_r <= gpio_pin;
            sync2_r <= sync1_r;
        end
    end

`ifdef GPIO_IRQ_DEBOUNCE_EN
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CNT - 1);

    logic [31:0] filt_r;
    logic [7:0]  cnt_r [32];

    // Debounce: a bit adopts the synchronized level only after it has differed
    // from the filtered value for DEBOUNCE_CNT consecutive cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_r <= 32'h0;
            for (int i = 0; i < 32; i++) begin
                cnt_r[i] <= 8'h0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (sync2_r[i] != filt_r[i]) begin
                    if (cnt_r[i] == CNT_LAST) begin
                        filt_r[i] <= sync2_r[i];
                        cnt_r[i]  <= 8'h0;
                    end else begin
                        cnt_r[i]  <= cnt_r[i] + 8'h1;
                    end
                end else begin
                    cnt_r[i] <= 8'h0;
                end
            end
        end
    end

    assign gpio_sync_s = filt_r;
`else
    assign gpio_sync_s = sync2_r;
`endif

    assign gpio_sync = gpio_sync_s;

    // Bus write decode and edge-event detection against the delayed pin copy.
    always_comb begin
        addr_s  = bus_addr[7:0];
        wr_en_s = bus_valid & bus_we;
        if (wr_en_s && (addr_s == ADDR_STATUS)) begin
            w1c_s = bus_wdata;
        end else begin
            w1c_s = 32'h0;
        end
        edge_set_s = irq_en_r & ((gpio_sync_s & ~prev_r & irq_rise_r) |
                                 (~gpio_sync_s & prev_r & irq_fall_r));
    end

    // Configuration registers: enable, rising-edge and falling-edge selects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en_r   <= 32'h0;
            irq_rise_r <= 32'h0;
            irq_fall_r <= 32'h0;
        end else if (wr_en_s) begin
            case (addr_s)
                ADDR_EN:   irq_en_r   <= bus_wdata;
                ADDR_RISE: irq_rise_r <= bus_wdata;
                ADDR_FALL: irq_fall_r <= bus_wdata;
                default:   irq_en_r   <= irq_en_r;
            endcase
        end else begin
            irq_en_r <= irq_en_r;
        end
    end

    // Sticky status with write-1-to-clear; a same-cycle set beats the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r       <= 32'h0;
            irq_status_r <= 32'h0;
        end else begin
            prev_r       <= gpio_sync_s;
            irq_status_r <= (irq_status_r & ~w1c_s) | edge_set_s;
        end
    end

    // Combinational read mux; unmapped offsets read as zero.
    always_comb begin
        case (addr_s)
            ADDR_EN:     bus_rdata = irq_en_r;
            ADDR_RISE:   bus_rdata = irq_rise_r;
            ADDR_FALL:   bus_rdata = irq_fall_r;
            ADDR_STATUS: bus_rdata = irq_status_r;
            ADDR_PIN:    bus_rdata = gpio_sync_s;
            default:     bus_rdata = 32'h0;
        endcase
    end

    assign irq = |(irq_status_r & irq_en_r);

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Scoreboard bench for gpio_irq_ctrl: stimulus pushes expected read results
// from a behavioural model; a negedge monitor pops and compares on each read.
module tb_gpio_irq_ctrl;
    localparam int DEBOUNCE_CNT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic [31:0] gpio_pin;
    logic [31:0] gpio_sync;
    logic        irq;

    gpio_irq_ctrl #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus_valid(bus_valid),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .gpio_pin (gpio_pin),
        .gpio_sync(gpio_sync),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] rdata;
        logic        irq;
        logic [31:0] sync;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural model: register values, visible pin state, pin sample history.
    logic [31:0] m_en, m_rise, m_fall, m_status;
    logic [31:0] m_gs, m_prev;
    logic [31:0] m_last, m_last2;   // pad samples taken one and two edges ago
    int          m_run [32];
    logic [31:0] pin_v;

    task automatic model_reset();
        m_en = 32'h0; m_rise = 32'h0; m_fall = 32'h0; m_status = 32'h0;
        m_gs = 32'h0; m_prev = 32'h0; m_last = 32'h0; m_last2 = 32'h0;
        for (int i = 0; i < 32; i++) m_run[i] = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        case (a)
            8'h00:   return m_en;
            8'h04:   return m_rise;
            8'h08:   return m_fall;
            8'h0C:   return m_status;
            8'h10:   return m_gs;
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model across one clock edge using the inputs present at it.
    task automatic model_edge();
        logic [31:0] ev, w1c;
        logic [7:0]  a;
        ev  = m_en & ((m_gs & ~m_prev & m_rise) | (~m_gs & m_prev & m_fall));
        a   = bus_addr[7:0];
        w1c = 32'h0;
        m_prev = m_gs;
`ifdef GPIO_IRQ_DEBOUNCE_EN
        // pin level must differ from the visible value for DEBOUNCE_CNT edges in a row
        for (int i = 0; i < 32; i++) begin
            if (m_last2[i] != m_gs[i]) begin
                m_run[i]++;
                if (m_run[i] == DEBOUNCE_CNT) begin
                    m_gs[i]  = m_last2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
`else
        // pad sampled at edge N is visible after edge N+1
        m_gs = m_last;
`endif
        m_last2 = m_last;
        m_last  = gpio_pin;
        if (bus_valid && bus_we) begin
            case (a)
                8'h00:   m_en   = bus_wdata;
                8'h04:   m_rise = bus_wdata;
                8'h08:   m_fall = bus_wdata;
                8'h0C:   w1c    = bus_wdata;
                default: ;
            endcase
        end
        m_status = (m_status & ~w1c) | ev;
    endtask

    // One bus cycle: drive inputs, queue any read expectation, cross the edge.
    task automatic step(input logic r, input logic v, input logic we,
                        input logic [7:0] a, input logic [31:0] wd);
        exp_t e;
        rst       = r;
        bus_valid = v;
        bus_we    = we;
        bus_addr  = {24'($urandom), a};
        bus_wdata = wd;
        gpio_pin  = pin_v;
        if (r) model_reset();
        if (v && !we) begin
            e.addr  = a;
            e.rdata = model_read(a);
            e.irq   = |(m_status & m_en);
            e.sync  = m_gs;
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (r) model_reset();
        else   model_edge();
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [7:0] a);
        step(1'b0, 1'b1, 1'b0, a, 32'($urandom));
    endtask

    task automatic check(input string name, input logic [7:0] a,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s addr=0x%02h actual=0x%08h expected=0x%08h", name, a, act, exp);
        end
    endtask

    // Monitor: every read presented to the DUT is compared against the queue head.
    always @(negedge clk) begin
        if (bus_valid === 1'b1 && bus_we === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_underflow actual=empty expected=entry");
            end else begin
                mon_e = exp_q.pop_front();
                check("rdata", mon_e.addr, bus_rdata, mon_e.rdata);
                check("irq", mon_e.addr, {31'h0, irq}, {31'h0, mon_e.irq});
                check("gpio_sync", mon_e.addr, gpio_sync, mon_e.sync);
            end
        end
    end

    initial begin
        logic [7:0] atab [8];
        int         op;
        atab[0] = 8'h00; atab[1] = 8'h04; atab[2] = 8'h08; atab[3] = 8'h0C;
        atab[4] = 8'h10; atab[5] = 8'h14; atab[6] = 8'hFC; atab[7] = 8'h0E;
        pin_v = 32'h0;
        model_reset();
        rst = 1'b1; bus_valid = 1'b0; bus_we = 1'b0;
        bus_addr = 32'h0; bus_wdata = 32'h0; gpio_pin = 32'h0;
        @(posedge clk); #1;

        // reads while reset is held, then after release
        step(1'b1, 1'b1, 1'b0, 8'h0C, 32'h0);
        for (int i = 0; i < 4; i++) rd(atab[i]);

        // single rising edge on pin 0, then W1C
        wr(8'h00, 32'h1); wr(8'h04, 32'h1);
        pin_v[0] = 1'b1;
        for (int i = 0; i < 4; i++) rd(8'h0C);
        wr(8'h0C, 32'h1);
        rd(8'h0C); rd(8'h10);

        // both edges on pin 7 with a clear between them
        wr(8'h00, 32'h80); wr(8'h04, 32'h80); wr(8'h08, 32'h80);
        pin_v[7] = 1'b1;
        for (int i = 0; i < 4; i++) rd(8'h0C);
        wr(8'h0C, 32'h80);
        pin_v[7] = 1'b0;
        for (int i = 0; i < 4; i++) rd(8'h0C);

        // set and W1C on bit 3 in the same cycle
        wr(8'h00, 32'h08); wr(8'h04, 32'h08);
        pin_v[3] = 1'b1;
        rd(8'h0C); rd(8'h0C);
        wr(8'h0C, 32'h08);
        rd(8'h0C); rd(8'h0C);

        // masking on pin 4
        wr(8'h00, 32'h0); wr(8'h04, 32'h10); wr(8'h0C, 32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++) begin pin_v[4] = ~pin_v[4]; rd(8'h0C); end
        pin_v[4] = 1'b0; rd(8'h0C); rd(8'h0C); rd(8'h0C);
        wr(8'h00, 32'h10);
        pin_v[4] = 1'b1;
        for (int i = 0; i < 4; i++) rd(8'h0C);
        wr(8'h00, 32'h0);
        rd(8'h0C); rd(8'h00);

        // short glitch then a long level on pin 2
        wr(8'h00, 32'h04); wr(8'h04, 32'h04); wr(8'h0C, 32'hFFFF_FFFF);
        pin_v[2] = 1'b1;
        for (int i = 0; i < 5; i++) rd(8'h10);
        pin_v[2] = 1'b0;
        for (int i = 0; i < 12; i++) rd(8'h0C);
        pin_v[2] = 1'b1;
        for (int i = 0; i < 12; i++) rd(8'h10);
        for (int i = 0; i < 4; i++) rd(8'h0C);

        // asynchronous reset mid-operation
        step(1'b1, 1'b1, 1'b0, 8'h00, 32'h0);
        step(1'b1, 1'b1, 1'b0, 8'h0C, 32'h0);
        rd(8'h0C); rd(8'h10);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            pin_v = pin_v ^ ($urandom & $urandom & $urandom & $urandom);
            op = $urandom_range(0, 399);
            if (op == 0) begin
                step(1'b1, 1'b1, 1'b0, atab[$urandom_range(0, 7)], 32'h0);
            end else if (op < 180) begin
                rd(atab[$urandom_range(0, 7)]);
            end else if (op < 260) begin
                wr(atab[$urandom_range(0, 7)], $urandom);
            end else begin
                step(1'b0, 1'b0, 1'($urandom), 8'($urandom), $urandom);
            end
        end

        step(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gpio_irq_ctrl.md
GPIO_IRQ_CTRL -- requirements
Module: gpio_irq_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CNT, default 8: consecutive stable cycles required by the debounce filter (used only when GPIO_IRQ_DEBOUNCE_EN is defined); legal range 2..255.
REQ-002 clk  input  1  single clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 bus_valid  input  1  bus access strobe.
REQ-005 bus_we  input  1  1 = write, 0 = read.
REQ-006 bus_addr  input  32  byte address; only bits [7:0] are decoded.
REQ-007 bus_wdata  input  32  write data.
REQ-008 bus_rdata  output  32  read data, combinational from bus_addr.
REQ-009 gpio_pin  input  32  raw, asynchronous pad inputs.
REQ-010 gpio_sync  output  32  synchronized (and, if enabled, filtered) pin values; feeds the GPIO controller's gpio_in.
REQ-011 irq  output  1  level interrupt request.

Function
REQ-012 Register map (offset = bus_addr[7:0]): 0x00 IRQ_EN (RW), 0x04 IRQ_RISE (RW), 0x08 IRQ_FALL (RW), 0x0C IRQ_STATUS (R, write-1-to-clear), 0x10 PIN_STATE (RO, reads gpio_sync).
REQ-013 Writes take effect on the clk edge where bus_valid=1 and bus_we=1; writes to 0x10 or unmapped offsets are ignored.
REQ-014 Reads are combinational and independent of bus_valid; unmapped offsets return 32'h0.
REQ-015 Each gpio_pin bit passes through a two-flop synchronizer; without debounce, gpio_sync equals the second flop, so a pin change sampled at edge N appears on gpio_sync after edge N+1.
REQ-016 A delayed copy prev = gpio_sync is registered every cycle; rise[i] = gpio_sync[i] & ~prev[i], fall[i] = ~gpio_sync[i] & prev[i].
REQ-017 IRQ_STATUS[i] sets on the edge following gpio_sync[i] changing, when IRQ_EN[i]=1 and ((rise[i] & IRQ_RISE[i]) | (fall[i] & IRQ_FALL[i])).
REQ-018 A bit with both IRQ_RISE and IRQ_FALL set triggers on either edge; a bit with neither set never sets.
REQ-019 Writing 1 to IRQ_STATUS[i] clears it; writing 0 leaves it unchanged.
REQ-020 A set event and a W1C of the same bit in the same cycle: set wins, and the bit reads 1 afterwards.
REQ-021 Clearing IRQ_EN[i] does not clear IRQ_STATUS[i]; it only blocks new sets.
REQ-022 irq = |(IRQ_STATUS & IRQ_EN), combinational.
REQ-023 Status bits are sticky: repeated edges while a bit is set leave it set, and no count is kept.

Reset
REQ-024 While rst=1: IRQ_EN, IRQ_RISE, IRQ_FALL and IRQ_STATUS are 0, and the synchronizer flops, prev and gpio_sync are 0.
REQ-025 The irq output is 0 during reset.
REQ-026 If a debounce counter is implemented, it is 0 during reset.
REQ-027 No edge is reported on the first cycle after reset release; prev initialises from reset, so a pin held high at release produces one rise event once gpio_sync reaches 1.
REQ-028 Asserting rst mid-operation clears all state immediately, without waiting for clk.

Configuration
REQ-029 Macro GPIO_IRQ_DEBOUNCE_EN defined: each bit gets a counter.
- The counter increments while the synchronizer output differs from gpio_sync[i], and resets to 0 when they are equal.
- When the count reaches DEBOUNCE_CNT-1 and the difference persists, gpio_sync[i] takes the new value and the counter returns to 0.
- Net effect: a glitch shorter than DEBOUNCE_CNT cycles never reaches gpio_sync.
REQ-030 Macro GPIO_IRQ_DEBOUNCE_EN undefined: no counters are present and behaviour follows REQ-015 exactly.

Verification
REQ-031 Reset: after reset, read 0x00/0x04/0x08/0x0C -> all 32'h0; irq=0.
REQ-032 Rising edge: write IRQ_EN=0x1, IRQ_RISE=0x1; drive gpio_pin[0] 0->1 -> IRQ_STATUS=0x1 and irq=1 within 3 cycles; write 0x0C=0x1 -> IRQ_STATUS=0x0 and irq=0.
REQ-033 Both edges: IRQ_EN=0x80, IRQ_RISE=0x80, IRQ_FALL=0x80; pulse pin 7 high for 5 cycles, then clear status between the two edges -> status sets twice.
REQ-034 Collision: force a bit-3 edge in the same cycle as a 0x0C=0x8 write -> IRQ_STATUS[3]=1 afterwards.
REQ-035 Masking: IRQ_EN=0 and pin 4 toggles -> status stays 0; with status[4]=1, write IRQ_EN=0 -> irq=0 but status still reads 0x10.
REQ-036 Debounce (macro on, DEBOUNCE_CNT=8): a 5-cycle glitch on pin 2 -> gpio_sync[2] unchanged and no status; a 12-cycle level -> gpio_sync[2]=1 and status[2]=1.
